// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes and MDU state encoding for alu_mdu
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_SLL  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_SLTU = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_NOR  = 4'd12;

    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_t;

endpackage

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative radix-2 multiply/divide unit owning HI/LO
module mdu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       md_op,
    input  logic             start,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t          state, state_nxt;
    logic [SHW-1:0]     cnt;
    logic [WIDTH-1:0]   acc, quo, mag_b, a_raw;
    logic [1:0]         op_q;
    logic               neg_a, neg_b;

    logic               accept, signed_in, neg_a_in, neg_b_in, is_div;
    logic [WIDTH-1:0]   mag_a_in, mag_b_in;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ok;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s;

    assign accept    = start && (state == MD_IDLE) && !flush;
    assign signed_in = (md_op == MD_MULT) || (md_op == MD_DIV);
    assign neg_a_in  = signed_in && a[WIDTH-1];
    assign neg_b_in  = signed_in && b[WIDTH-1];
    assign mag_a_in  = neg_a_in ? -a : a;
    assign mag_b_in  = neg_b_in ? -b : b;
    assign is_div    = (op_q == MD_DIV) || (op_q == MD_DIVU);

    // Multiply: {acc,quo} shifts right, quo[0] selects whether the multiplicand is added.
    assign mul_sum   = {1'b0, acc} + ({1'b0, mag_b} & {(WIDTH+1){quo[0]}});
    // Divide: restoring step; a passing trial subtraction leaves a value below the divisor,
    // so both top bits of the difference are clear exactly when the step succeeds.
    assign div_shift = {acc, quo[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, mag_b};
    assign div_ok    = (div_diff[WIDTH+1:WIDTH] == 2'b00);

    assign prod      = {acc, quo};
    assign prod_s    = (neg_a ^ neg_b) ? -prod : prod;
    assign quo_s     = (neg_a ^ neg_b) ? -quo : quo;
    assign rem_s     = neg_a ? -acc : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (accept) state_nxt = MD_RUN;
            MD_RUN: begin
                if (flush)              state_nxt = MD_IDLE;
                else if (cnt == '0)     state_nxt = MD_FIX;
            end
            MD_FIX:  state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != MD_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            acc   <= '0;
            quo   <= '0;
            mag_b <= '0;
            a_raw <= '0;
            op_q  <= MD_MULT;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
            done  <= 1'b0;
            div0  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= (state == MD_FIX) && !flush;
            if (accept) begin
                cnt   <= SHW'(WIDTH - 1);
                acc   <= '0;
                quo   <= mag_a_in;
                mag_b <= mag_b_in;
                a_raw <= a;
                op_q  <= md_op;
                neg_a <= neg_a_in;
                neg_b <= neg_b_in;
            end else if (state == MD_RUN && !flush) begin
                cnt <= cnt - 1'b1;
                if (is_div) begin
                    acc <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], div_ok};
                end else begin
                    acc <= mul_sum[WIDTH:1];
                    quo <= {mul_sum[0], quo[WIDTH-1:1]};
                end
            end
            if (state == MD_FIX && !flush) begin
                if (!is_div) begin
                    {hi, lo} <= prod_s;
                end else if (mag_b == '0) begin
                    lo   <= '1;
                    hi   <= a_raw;
                    div0 <= 1'b1;
                end else begin
                    lo   <= quo_s;
                    hi   <= rem_s;
                    div0 <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - execute-stage ALU with iterative multiply/divide unit
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] out,
    output logic             flag_zero,
    output logic             flag_ovf,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    input  logic             md_flush,
    output logic             md_busy,
    output logic             md_done,
    output logic             md_div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] sum, diff;
    logic [SHW-1:0]   sh;

    assign sum  = a + b;
    assign diff = a - b;
    assign sh   = b[SHW-1:0];

    always_comb begin
        out = '0;
        case (op)
            ALU_AND:  out = a & b;
            ALU_OR:   out = a | b;
            ALU_ADD:  out = sum;
            ALU_XOR:  out = a ^ b;
            ALU_SLL:  out = a << sh;
            ALU_SRL:  out = a >> sh;
            ALU_SUB:  out = diff;
            ALU_SLT:  out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: out = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_SRA:  out = $signed(a) >>> sh;
            ALU_NOR:  out = ~(a | b);
            default:  out = '0;
        endcase
    end

    assign flag_zero = (out == '0);

    always_comb begin
        flag_ovf = 1'b0;
        if (op == ALU_ADD)
            flag_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        else if (op == ALU_SUB)
            flag_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    end

    mdu_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_mdu (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .md_op (md_op),
        .start (md_start),
        .flush (md_flush),
        .busy  (md_busy),
        .done  (md_done),
        .div0  (md_div0),
        .hi    (hi),
        .lo    (lo)
    );

endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - self-checking bench for alu_mdu at WIDTH 32, 16 and 8
module tb_alu_mdu;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] a, b, out, hi, lo;
    logic [3:0]  op;
    logic        flag_zero, flag_ovf, md_start, md_flush, md_busy, md_done, md_div0;
    logic [1:0]  md_op;

    logic [7:0]  a8, b8, out8, hi8, lo8;
    logic [15:0] a16, b16, out16, hi16, lo16;
    logic [3:0]  op_s;
    logic [1:0]  md_op_s;
    logic        start_s, flush_s;
    logic        z8, v8, busy8, done8, div08, z16, v16, busy16, done16, div016;

    alu_mdu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op), .out(out),
        .flag_zero(flag_zero), .flag_ovf(flag_ovf), .md_start(md_start), .md_op(md_op),
        .md_flush(md_flush), .md_busy(md_busy), .md_done(md_done), .md_div0(md_div0),
        .hi(hi), .lo(lo)
    );

    alu_mdu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .op(op_s), .out(out8),
        .flag_zero(z8), .flag_ovf(v8), .md_start(start_s), .md_op(md_op_s),
        .md_flush(flush_s), .md_busy(busy8), .md_done(done8), .md_div0(div08),
        .hi(hi8), .lo(lo8)
    );

    alu_mdu #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .op(op_s), .out(out16),
        .flag_zero(z16), .flag_ovf(v16), .md_start(start_s), .md_op(md_op_s),
        .md_flush(flush_s), .md_busy(busy16), .md_done(done16), .md_div0(div016),
        .hi(hi16), .lo(lo16)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, out;
        logic        z, ovf;
    } alu_vec_t;

    typedef struct {
        logic [31:0] hi, lo;
        logic        div0;
    } exp_t;

    alu_vec_t tv[$];
    exp_t     sb[$];
    int       n_vec = 0;
    int       n_bad = 0;
    logic     exp_div0 = 1'b0, exp_div0_8 = 1'b0, exp_div0_16 = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void mdu_model(input int n, input logic [1:0] mop,
                                      input logic [31:0] ra, input logic [31:0] rb,
                                      output logic [31:0] ehi, output logic [31:0] elo,
                                      inout logic div0);
        longint unsigned mask, ua, ub, up;
        longint          sa, sb2, p, q, r;
        mask = (64'd1 << n) - 64'd1;
        ua   = {32'd0, ra} & mask;
        ub   = {32'd0, rb} & mask;
        sa   = ua[n-1] ? longint'(ua) - longint'(64'd1 << n) : longint'(ua);
        sb2  = ub[n-1] ? longint'(ub) - longint'(64'd1 << n) : longint'(ub);
        ehi  = '0;
        elo  = '0;
        case (mop)
            MD_MULT: begin
                p   = sa * sb2;
                ehi = 32'((longint'(p) >>> n) & longint'(mask));
                elo = 32'(p & longint'(mask));
            end
            MD_MULTU: begin
                up  = ua * ub;
                ehi = 32'((up >> n) & mask);
                elo = 32'(up & mask);
            end
            default: begin
                if (ub == 0) begin
                    elo  = 32'(mask);
                    ehi  = 32'(ua);
                    div0 = 1'b1;
                end else begin
                    if (mop == MD_DIV) begin
                        q = sa / sb2;
                        r = sa % sb2;
                    end else begin
                        q = longint'(ua / ub);
                        r = longint'(ua % ub);
                    end
                    elo  = 32'(q & longint'(mask));
                    ehi  = 32'(r & longint'(mask));
                    div0 = 1'b0;
                end
            end
        endcase
    endfunction

    // Scoreboard: every completion must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && md_done) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL md_done_unexpected: got 1 expected 0");
            end else begin
                e = sb.pop_front();
                check("mdu_hi", hi, e.hi);
                check("mdu_lo", lo, e.lo);
                check("mdu_div0", md_div0, e.div0);
            end
        end
    end

    task automatic issue(input logic [1:0] mop, input logic [31:0] ra, input logic [31:0] rb,
                         input bit track);
        exp_t e;
        @(negedge clk);
        a = ra; b = rb; md_op = mop; md_start = 1'b1;
        if (track) begin
            mdu_model(32, mop, ra, rb, e.hi, e.lo, exp_div0);
            e.div0 = exp_div0;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 md_start = 1'b0;
    endtask

    task automatic wait_done(input int start_cyc, input int exp_cyc, input string name);
        int  c = start_cyc;
        bit  seen = 1'b0;
        while (c < 200 && !seen) begin
            @(posedge clk);
            c++;
            #1 seen = md_done;
        end
        check(name, c, exp_cyc);
    endtask

    task automatic run_small(input logic [1:0] mop, input logic [31:0] ra, input logic [31:0] rb);
        logic [31:0] eh, el;
        logic [31:0] gh8 = '0, gl8 = '0, gh16 = '0, gl16 = '0;
        logic        gd8 = 1'b0, gd16 = 1'b0;
        int          c8 = 0, c16 = 0;
        @(negedge clk);
        a8 = ra[7:0]; b8 = rb[7:0]; a16 = ra[15:0]; b16 = rb[15:0];
        md_op_s = mop; start_s = 1'b1;
        @(posedge clk);
        #1 start_s = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done8 && c8 == 0) begin
                c8 = i; gh8 = 32'(hi8); gl8 = 32'(lo8); gd8 = div08;
            end
            if (done16 && c16 == 0) begin
                c16 = i; gh16 = 32'(hi16); gl16 = 32'(lo16); gd16 = div016;
            end
        end
        check("w8_latency", c8, 9);
        check("w16_latency", c16, 17);
        mdu_model(8, mop, ra, rb, eh, el, exp_div0_8);
        check("w8_hi", gh8, eh);
        check("w8_lo", gl8, el);
        check("w8_div0", gd8, exp_div0_8);
        mdu_model(16, mop, ra, rb, eh, el, exp_div0_16);
        check("w16_hi", gh16, eh);
        check("w16_lo", gl16, el);
        check("w16_div0", gd16, exp_div0_16);
    endtask

    initial begin
        int dones;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        rst_n = 1'b0; a = '0; b = '0; op = '0; md_start = 1'b0; md_op = '0; md_flush = 1'b0;
        a8 = '0; b8 = '0; a16 = '0; b16 = '0; op_s = '0; md_op_s = '0; start_s = 1'b0; flush_s = 1'b0;
        #2;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", md_busy, 0);
        check("rst_done", md_done, 0);
        check("rst_div0", md_div0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        tv.push_back(alu_vec_t'{ALU_SLT,  32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0});
        tv.push_back(alu_vec_t'{ALU_SLTU, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0});
        tv.push_back(alu_vec_t'{ALU_ADD,  32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b1});
        tv.push_back(alu_vec_t'{ALU_SRA,  32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1'b0});
        tv.push_back(alu_vec_t'{ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0});
        tv.push_back(alu_vec_t'{ALU_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0});
        tv.push_back(alu_vec_t'{ALU_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0});
        tv.push_back(alu_vec_t'{ALU_NOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, 1'b0});
        tv.push_back(alu_vec_t'{ALU_SLL,  32'h00000001, 32'd31,       32'h80000000, 1'b0, 1'b0});
        tv.push_back(alu_vec_t'{ALU_SRL,  32'h80000000, 32'h21,       32'h40000000, 1'b0, 1'b0});
        tv.push_back(alu_vec_t'{ALU_SUB,  32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, 1'b1});
        tv.push_back(alu_vec_t'{ALU_SUB,  32'd5,        32'd5,        32'd0,        1'b1, 1'b0});
        tv.push_back(alu_vec_t'{ALU_ADD,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0});
        tv.push_back(alu_vec_t'{4'd10,    32'h12345678, 32'h1,        32'd0,        1'b1, 1'b0});
        tv.push_back(alu_vec_t'{4'd15,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1'b1, 1'b0});
        tv.push_back(alu_vec_t'{ALU_SLT,  32'd1,        32'hFFFFFFFF, 32'd0,        1'b1, 1'b0});
        tv.push_back(alu_vec_t'{ALU_SLTU, 32'd1,        32'hFFFFFFFF, 32'd1,        1'b0, 1'b0});
        foreach (tv[i]) begin
            op = tv[i].op; a = tv[i].a; b = tv[i].b;
            #1;
            check($sformatf("alu%0d_out", i), out, tv[i].out);
            check($sformatf("alu%0d_zero", i), flag_zero, tv[i].z);
            check($sformatf("alu%0d_ovf", i), flag_ovf, tv[i].ovf);
        end

        issue(MD_DIVU, 32'd7, 32'd0, 1'b1);
        wait_done(0, 33, "divu0_latency");

        issue(MD_MULT, 32'hFFFFFFFE, 32'd3, 1'b1);
        repeat (10) @(posedge clk);
        #1 a = 32'd99; b = 32'd5; md_op = MD_DIVU; md_start = 1'b1;
        @(posedge clk);
        #1 md_start = 1'b0;
        check("busy_during_mult", md_busy, 1);
        wait_done(11, 33, "mult_latency");

        issue(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b1);
        wait_done(0, 33, "div_latency");
        @(negedge clk);
        check("div_hi_hold", hi, 32'hFFFFFFFF);
        check("div_lo_hold", lo, 32'hFFFFFFFD);

        issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        repeat (4) @(posedge clk);
        #1 md_flush = 1'b1;
        @(posedge clk);
        #1 md_flush = 1'b0;
        check("flush_busy", md_busy, 0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 if (md_done) dones++;
        end
        check("flush_no_done", dones, 0);
        check("flush_hi_kept", hi, 32'hFFFFFFFF);
        check("flush_lo_kept", lo, 32'hFFFFFFFD);

        issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        wait_done(0, 33, "reissue_latency");
        issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        wait_done(0, 33, "b2b_latency");

        @(negedge clk);
        md_start = 1'b1; md_flush = 1'b1; md_op = MD_MULT;
        @(posedge clk);
        #1 md_start = 1'b0; md_flush = 1'b0;
        check("flush_blocks_start", md_busy, 0);

        for (int i = 0; i < 12; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i % 4 == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            issue(rop, ra, rb, 1'b1);
            wait_done(0, 33, "rand_latency");
        end

        issue(MD_DIVU, 32'd5, 32'd0, 1'b1);
        wait_done(0, 33, "pre_reset_latency");
        issue(MD_DIV, 32'd100, 32'd7, 1'b0);
        repeat (7) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("areset_busy", md_busy, 0);
        check("areset_hi", hi, 0);
        check("areset_lo", lo, 0);
        check("areset_div0", md_div0, 0);
        exp_div0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        op_s = ALU_SRA; a8 = 8'h80; b8 = 8'd4; a16 = 16'h8000; b16 = 16'd4;
        #1;
        check("w8_sra", out8, 8'hF8);
        check("w16_sra", out16, 16'hF800);
        op_s = ALU_ADD; a8 = 8'h7F; b8 = 8'd1; a16 = 16'h7FFF; b16 = 16'd1;
        #1;
        check("w8_add_ovf", v8, 1);
        check("w16_add_ovf", v16, 1);
        op_s = ALU_SLT; a8 = 8'hFF; b8 = 8'd1;
        #1;
        check("w8_slt", out8, 8'd1);

        run_small(MD_MULT,  32'hFFFFFFFE, 32'd3);
        run_small(MD_DIV,   32'hFFFFFFF9, 32'd2);
        run_small(MD_DIVU,  32'd7,        32'd0);
        run_small(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_small(MD_DIV,   32'h00000080, 32'hFFFFFFFF);
        for (int i = 0; i < 8; i++) begin
            run_small(2'($urandom_range(0, 3)), $urandom, (i % 3 == 0) ? 32'd0 : $urandom);
        end

        repeat (3) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Next-generation execute-stage arithmetic unit for the pipelined MIPS core.
- Width-parametrised single-cycle ALU, extended with shifts, XOR, signed/unsigned compare and signed overflow detection.
- Adds an iterative multiply/divide unit (MDU) that owns architectural HI/LO and exposes a start/busy/done handshake.
- The hazard unit stalls MFHI/MFLO and new MDU ops on busy.

Parameters:
- WIDTH, 32: datapath width; must be a power of 2 and at least 8.
- SHW, $clog2(WIDTH): shift-amount width, derived; do not override.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- a  in  WIDTH  operand A (rs)
- b  in  WIDTH  operand B (rt / immediate)
- op  in  4  ALU operation select
- out  out  WIDTH  ALU result, combinational
- flag_zero  out  1  out == 0, combinational
- flag_ovf  out  1  signed overflow on ADD/SUB, combinational
- md_start  in  1  launch an MDU operation using a, b, md_op
- md_op  in  2  0 MULT, 1 MULTU, 2 DIV, 3 DIVU
- md_flush  in  1  abort the in-flight MDU op (pipeline flush)
- md_busy  out  1  MDU iterating
- md_done  out  1  one-cycle pulse: HI/LO updated this cycle
- md_div0  out  1  sticky: last completed DIV/DIVU had divisor 0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset: rst_n low asynchronously clears hi, lo, md_busy, md_done, md_div0, iteration counter and all internal registers. ALU outputs remain purely combinational.
- ALU op encoding:
  - 0 AND, 1 OR, 2 ADD, 3 XOR, 4 SLL, 5 SRL, 6 SUB
  - 7 SLT (signed; result is 1 or 0, never holds a previous value), 8 SLTU, 9 SRA, 12 NOR
  - 10, 11, 13–15 produce out = 0.
- Shift amount is b[SHW-1:0]; the shifted operand is a.
- flag_zero reflects the final out for every op.
- flag_ovf is 1 only for op 2/6 when the operand signs imply a sign-incorrect result; otherwise 0. Results wrap and no trap is raised.
- ALU path is independent of MDU state and has no latency.
- MDU launch:
  - md_start is accepted at a rising edge when md_busy = 0 and md_flush = 0.
  - a, b and md_op are captured at that edge.
  - md_start while busy is ignored; it is neither queued nor does it disturb the op in flight.
- MDU states: IDLE -> RUN (WIDTH cycles, one radix-2 step per cycle) -> FIX (1 cycle: sign correction and HI/LO write) -> IDLE.
  - md_busy = 1 in RUN and FIX.
  - Total latency: HI/LO are valid and md_done = 1 exactly WIDTH+1 cycles after the accept edge.
  - md_busy falls at that same edge.
- Back-to-back issue: md_start may be accepted in the cycle md_done is high.
- Signed ops operate on magnitudes; the sign is applied in FIX.
- MULT/MULTU: {hi, lo} = full 2*WIDTH product.
- DIV/DIVU: lo = quotient, hi = remainder. Quotient truncates toward zero; remainder takes the sign of the dividend.
- Divisor 0: lo = all ones, hi = dividend a, md_div0 = 1. Any non-zero-divisor DIV/DIVU completion clears md_div0; MULT/MULTU leave it unchanged.
- DIV with most-negative dividend and divisor -1: lo = most-negative value, hi = 0, with no exception.
- md_flush during RUN/FIX: returns to IDLE next edge, hi/lo unchanged, no md_done. A flush in the same cycle as md_start prevents the accept.
- Reset mid-operation: immediate abort; hi = lo = 0.

Decomposition:
- Shared package alu_pkg holds:
  - localparams for the ALU op codes (ALU_AND … ALU_NOR)
  - MD_MULT/MD_MULTU/MD_DIV/MD_DIVU encodings
  - MDU state encoding
- Natural sub-module: mdu_iter, containing the shift-add/restoring-divide datapath, counter and FSM.
- alu_mdu instantiates mdu_iter beside the combinational ALU case statement.

Test Plan:
- WIDTH=32, op 7, a=0xFFFFFFFF, b=1 -> out=1, flag_zero=0. Then op 8 with the same operands -> out=0, flag_zero=1, with no stale value held.
- op 2, a=0x7FFFFFFF, b=1 -> out=0x80000000, flag_ovf=1. op 9, a=0x80000000, b=4 -> out=0xF8000000.
- MULT a=0xFFFFFFFE (-2), b=3 -> md_done exactly 33 cycles after accept; hi=0xFFFFFFFF, lo=0xFFFFFFFA. md_start pulsed at cycle 10 of the op is ignored.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7, md_div0=1.
- MULTU a=b=0xFFFFFFFF, md_flush at cycle 5 -> no md_done, hi/lo keep prior values. Immediate re-issue completes with hi=0xFFFFFFFE, lo=1.
- rst_n low mid-DIV, asynchronous to clk -> md_busy, hi, lo, md_div0 = 0 before the next edge. Repeat the suite at WIDTH=8 and WIDTH=16.
